risc8_prog_loader: RTL and testbench
====================================

// Module: risc8_prog_loader
// PURPOSE
//  Writer side of the RISC8 instruction memory: receives a framed program image as a byte stream
//  and writes it into the 256x8 instr memory. The core only reads that memory.
//  Holds the core in reset (cpu_reset) until a frame has loaded and its checksum has verified.
//  Sits between the board byte source (UART/debug bridge) and the imem write port plus core reset.
// PARAMETERS
//  ADDR_W        8      imem address width; image length limit is 2**ADDR_W bytes
//  SYNC_BYTE     8'hA5  frame start marker
//  TIMEOUT_CYC   1023   idle cycles allowed between accepted bytes inside a frame
// PORTS
//  clk         in   1       rising-edge clock
//  reset       in   1       asynchronous, active-high
//  in_valid    in   1       byte available
//  in_data     in   8       byte value
//  in_ready    out  1       loader accepts; byte transfers when in_valid & in_ready
//  imem_we     out  1       instr-memory write strobe, one cycle per payload byte
//  imem_addr   out  ADDR_W  write address
//  imem_wdata  out  8       write data
//  cpu_reset   out  1       high = core held in reset
//  done        out  1       high = last frame loaded and verified
//  err         out  1       sticky: last frame failed (checksum or timeout)
//  byte_cnt    out  ADDR_W  payload bytes written in current/last frame (mod 2**ADDR_W)
// BEHAVIOUR
//  Reset values: cpu_reset=1; all other outputs 0. FSM state = IDLE.
//  in_ready = 1 in every state once out of reset. The loader never back-pressures.
//  Frame format: SYNC_BYTE, LEN, LEN payload bytes, CHK.
//   LEN=0 means 256 bytes. CHK passes when (sum of payload + CHK) mod 256 == 0.
//  FSM states:
//   IDLE: discard every byte except SYNC_BYTE. On SYNC -> LEN, cpu_reset=1, done=0, err=0, byte_cnt=0.
//   LEN: latch LEN into remaining count (0 -> 256), clear sum -> DATA.
//   DATA: each accepted byte is registered. Next cycle: imem_we=1, imem_addr=byte_cnt,
//    imem_wdata=byte. byte_cnt+1, sum+=byte (8-bit wrap), remaining-1.
//    After the last payload byte -> CHK.
//   CHK: if (sum+byte)==0 -> DONE (next cycle: cpu_reset=0, done=1).
//    Otherwise -> IDLE with err=1 and cpu_reset kept at 1.
//   DONE: core runs. A SYNC_BYTE restarts the load: -> LEN, next cycle cpu_reset=1 and done=0.
//    Other bytes are discarded.
//  Write latency: exactly 1 cycle from payload acceptance to imem_we.
//   Back-to-back bytes give back-to-back writes. Addresses wrap within 2**ADDR_W.
//  A SYNC_BYTE value inside LEN/DATA/CHK is plain data (no resync).
//  Timeout:
//   In LEN, DATA and CHK, a counter clears on every accepted byte and increments otherwise.
//   When it reaches TIMEOUT_CYC -> IDLE, err=1, cpu_reset stays 1.
//   Payload already written is not rolled back.
//   In IDLE and DONE the counter is held at 0.
//  Error leaves the core in reset. Recovery is only via a new frame; err clears on its SYNC.
//  Async reset mid-frame: immediate return to reset values. The partial image is abandoned.
// STRUCTURE
//  Include file risc8_loader_defs.vh holds:
//   - FSM state encodings (IDLE, LEN, DATA, CHK, DONE)
//   - SYNC_BYTE default
//   - frame format constants (shared with the host-side image packer)
//  Sub-module risc8_loader_timer: inter-byte timeout counter with clear/enable and
//   expired output, parameterised by TIMEOUT_CYC.
//  Top level holds: FSM, payload register, length/sum/address counters, output registers.
// TESTING
//  1 Reset -> cpu_reset=1, done=err=imem_we=0, in_ready=1 after reset drops.
//  2 Stream A5,03,11,22,33,9A -> writes 11@0,22@1,33@2, one cycle after each byte.
//    Then done=1, cpu_reset=0, byte_cnt=3.
//  3 Same frame with CHK=9B -> three writes occur, err=1, done=0, cpu_reset stays 1.
//    Then the good frame from test 2 -> err clears, done=1.
//  4 Frame A5,02,07, then idle TIMEOUT_CYC cycles -> err=1, FSM in IDLE, one write (07@0).
//  5 LEN=00 with payload 0..255 and CHK=80 -> 256 writes, addr wraps to byte_cnt=0, done=1.
//  6 In DONE send 12,A5 -> 12 ignored, cpu_reset=1 and done=0 the cycle after A5.
//    Async reset asserted mid-DATA -> all outputs at reset values immediately.

Source files
------------

// File: rtl/risc8_prog_loader_pkg.sv
// Shared definitions for the RISC8 program loader.
// Holds the FSM state encoding, the default frame start marker and the frame format
// constants that the host-side image packer must agree with.
package risc8_prog_loader_pkg;

    // Loader FSM states.
    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StLen  = 3'd1,
        StData = 3'd2,
        StChk  = 3'd3,
        StDone = 3'd4
    } state_e;

    // Frame format: SYNC, LEN, LEN payload bytes, CHK.
    localparam logic [7:0]  SyncByteDefault = 8'hA5;
    // A LEN byte of zero encodes a full 256-byte image.
    localparam int unsigned LenZeroBytes    = 256;
    // Remaining-count width; must hold LenZeroBytes.
    localparam int unsigned RemW            = 9;
    // Payload sum plus CHK must land on this value (mod 256).
    localparam logic [7:0]  ChkResidue      = 8'h00;

    // Convert the LEN byte into the number of payload bytes to expect.
    function automatic logic [RemW-1:0] len_to_count(input logic [7:0] len);
        return (len == 8'h00) ? RemW'(LenZeroBytes) : {1'b0, len};
    endfunction

    // Checksum verdict for the running payload sum and the received CHK byte.
    function automatic logic chk_ok(input logic [7:0] sum, input logic [7:0] chk);
        logic [7:0] total;
        total = sum + chk;
        return total == ChkResidue;
    endfunction

endpackage

// File: rtl/risc8_loader_timer.sv
// Inter-byte timeout counter for the RISC8 program loader.
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous, active-high
//   clr      synchronous clear (wins over en)
//   en       count one idle cycle
//   expired  counter has reached TIMEOUT_CYC (holds there until cleared)
module risc8_loader_timer #(
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CntW = ($clog2(TIMEOUT_CYC + 1) < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign expired = (cnt_q == CntW'(TIMEOUT_CYC));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            // Saturate so a stalled frame cannot wrap back into the allowed window.
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/risc8_prog_loader.sv
// RISC8 program loader: writer side of the 256x8 instruction memory.
// Receives a framed image (SYNC, LEN, payload, CHK) on a byte stream, writes the payload
// into imem one cycle after each byte arrives, and releases the core from reset only once
// the checksum has verified. Timeouts and bad checksums leave the core in reset with err set.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   in_valid/in_data    incoming byte stream
//   in_ready            always 1 once out of reset (no back-pressure)
//   imem_we/addr/wdata  instruction memory write port
//   cpu_reset           core held in reset while high
//   done                last frame loaded and verified
//   err                 last frame failed (checksum or timeout), sticky until next SYNC
//   byte_cnt            payload bytes written in current/last frame
module risc8_prog_loader
    import risc8_prog_loader_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter logic [7:0]  SYNC_BYTE   = SyncByteDefault,
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [7:0]        imem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] byte_cnt
);

    state_e            state_q, state_d;
    logic              ready_q;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [RemW-1:0]   rem_q, rem_d;
    logic [7:0]        sum_q, sum_d;

    logic accept;
    logic is_sync;
    logic in_frame;
    logic expired;
    logic timeout;
    logic start;

    assign accept   = in_valid & ready_q;
    assign is_sync  = (in_data == SYNC_BYTE);
    assign in_frame = (state_q == StLen) || (state_q == StData) || (state_q == StChk);
    // A byte arriving on the expiry cycle still counts; only a silent cycle times out.
    assign timeout  = in_frame & ~accept & expired;
    assign start    = accept & is_sync & ((state_q == StIdle) || (state_q == StDone));

    risc8_loader_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (accept | ~in_frame),
        .en      (in_frame),
        .expired (expired)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StLen;
            end
            StLen: begin
                if (accept) state_d = StData;
                else if (timeout) state_d = StIdle;
            end
            StData: begin
                if (accept) begin
                    if (rem_q == RemW'(1)) state_d = StChk;
                end else if (timeout) begin
                    state_d = StIdle;
                end
            end
            StChk: begin
                if (accept) state_d = chk_ok(sum_q, in_data) ? StDone : StIdle;
                else if (timeout) state_d = StIdle;
            end
            StDone: begin
                if (start) state_d = StLen;
            end
            default: state_d = StIdle;
        endcase
    end

    // Registered outputs and datapath next values.
    always_comb begin
        we_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_reset_d = cpu_reset_q;
        done_d      = done_q;
        err_d       = err_q;
        byte_cnt_d  = byte_cnt_q;
        rem_d       = rem_q;
        sum_d       = sum_q;

        if (start) begin
            cpu_reset_d = 1'b1;
            done_d      = 1'b0;
            err_d       = 1'b0;
            byte_cnt_d  = '0;
        end

        unique case (state_q)
            StLen: begin
                if (accept) begin
                    rem_d = len_to_count(in_data);
                    sum_d = 8'h00;
                end
            end
            StData: begin
                if (accept) begin
                    we_d       = 1'b1;
                    addr_d     = byte_cnt_q;
                    wdata_d    = in_data;
                    byte_cnt_d = byte_cnt_q + ADDR_W'(1);
                    sum_d      = sum_q + in_data;
                    rem_d      = rem_q - RemW'(1);
                end
            end
            StChk: begin
                if (accept) begin
                    if (chk_ok(sum_q, in_data)) begin
                        cpu_reset_d = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        // Abandoned frames keep whatever was already written; the core stays in reset.
        if (timeout) err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 8'h00;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            byte_cnt_q  <= '0;
            rem_q       <= '0;
            sum_q       <= 8'h00;
        end else begin
            ready_q     <= 1'b1;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
            err_q       <= err_d;
            byte_cnt_q  <= byte_cnt_d;
            rem_q       <= rem_d;
            sum_q       <= sum_d;
        end
    end

    assign in_ready   = ready_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_reset  = cpu_reset_q;
    assign done       = done_q;
    assign err        = err_q;
    assign byte_cnt   = byte_cnt_q;

endmodule

// File: tb/tb_risc8_prog_loader.sv
module tb_risc8_prog_loader;

    localparam int unsigned TIMEOUT = 1023;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       imem_we;
    logic [7:0] imem_addr;
    logic [7:0] imem_wdata;
    logic       cpu_reset;
    logic       done;
    logic       err;
    logic [7:0] byte_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] wr_addr[$];
    logic [7:0] wr_data[$];
    logic [7:0] pay[256];

    typedef struct {
        logic [7:0] len;
        logic [7:0] base;
        logic [7:0] step;
        logic [7:0] chk;
        logic       exp_done;
        logic       exp_err;
        logic       exp_cpu_reset;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t vecs[8];

    risc8_prog_loader #(
        .ADDR_W      (8),
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_CYC (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .err        (err),
        .byte_cnt   (byte_cnt)
    );

    always #5 clk = ~clk;

    // Write log, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset && imem_we) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    // Sends SYNC, LEN, payload from pay[], CHK with random idle gaps up to max_gap.
    task automatic send_frame(input logic [7:0] len, input logic [7:0] chk, input int max_gap);
        int n;
        n = (len == 8'h00) ? 256 : int'(len);
        send(8'hA5);
        idle($urandom_range(max_gap, 0));
        send(len);
        for (int i = 0; i < n; i++) begin
            idle($urandom_range(max_gap, 0));
            send(pay[i]);
        end
        idle($urandom_range(max_gap, 0));
        send(chk);
    endtask

    // Expected image: pay[i] at address i (mod 256), in order.
    task automatic check_writes(input string name, input int n);
        int bad;
        int m;
        bad = 0;
        check({name, "_count"}, wr_addr.size(), n);
        m = (wr_addr.size() < n) ? wr_addr.size() : n;
        for (int i = 0; i < m; i++) begin
            if (wr_addr[i] !== 8'(i) || wr_data[i] !== pay[i]) bad++;
        end
        check({name, "_content_bad"}, bad, 0);
    endtask

    task automatic load_test2_payload();
        pay[0] = 8'h11;
        pay[1] = 8'h22;
        pay[2] = 8'h33;
    endtask

    initial begin
        logic [7:0] sum;
        logic [7:0] chk;
        logic [7:0] b;
        int         len;
        int         k;
        bit         good;

        vecs[0] = '{8'h03, 8'h11, 8'h11, 8'h9A, 1'b1, 1'b0, 1'b0, 8'd3};
        vecs[1] = '{8'h03, 8'h11, 8'h11, 8'h9B, 1'b0, 1'b1, 1'b1, 8'd3};
        vecs[2] = '{8'h03, 8'h11, 8'h11, 8'h9A, 1'b1, 1'b0, 1'b0, 8'd3};
        vecs[3] = '{8'h01, 8'hA5, 8'h00, 8'h5B, 1'b1, 1'b0, 1'b0, 8'd1};
        vecs[4] = '{8'h02, 8'hA5, 8'h00, 8'hB6, 1'b1, 1'b0, 1'b0, 8'd2};
        vecs[5] = '{8'h00, 8'h00, 8'h01, 8'h80, 1'b1, 1'b0, 1'b0, 8'd0};
        vecs[6] = '{8'h04, 8'h01, 8'h01, 8'hF6, 1'b1, 1'b0, 1'b0, 8'd4};
        vecs[7] = '{8'h04, 8'h01, 8'h01, 8'h00, 1'b0, 1'b1, 1'b1, 8'd4};

        // Reset values.
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        idle(2);
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_we", imem_we, 0);
        check("rst_byte_cnt", byte_cnt, 0);
        check("rst_in_ready", in_ready, 0);
        reset = 1'b0;
        tick();
        check("in_ready_after_rst", in_ready, 1);

        // Good frame, write timing checked byte by byte.
        clear_log();
        send(8'hA5);
        send(8'h03);
        check("t2_no_we_after_len", imem_we, 0);
        send(8'h11);
        check("t2_we0", imem_we, 1);
        check("t2_addr0", imem_addr, 8'h00);
        check("t2_data0", imem_wdata, 8'h11);
        send(8'h22);
        check("t2_we1", imem_we, 1);
        check("t2_addr1", imem_addr, 8'h01);
        check("t2_data1", imem_wdata, 8'h22);
        send(8'h33);
        check("t2_addr2", imem_addr, 8'h02);
        check("t2_data2", imem_wdata, 8'h33);
        send(8'h9A);
        check("t2_no_we_on_chk", imem_we, 0);
        check("t2_done", done, 1);
        check("t2_cpu_reset", cpu_reset, 0);
        check("t2_byte_cnt", byte_cnt, 3);

        // DONE: junk ignored, SYNC restarts.
        clear_log();
        send(8'h12);
        check("t6_junk_done", done, 1);
        check("t6_junk_cpu_reset", cpu_reset, 0);
        tick();
        check("t6_junk_no_write", wr_addr.size(), 0);
        send(8'hA5);
        check("t6_sync_cpu_reset", cpu_reset, 1);
        check("t6_sync_done", done, 0);

        // Timeout: finish abandoned restart, then a fresh short frame that stalls.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        clear_log();
        pay[0] = 8'h07;
        send(8'hA5);
        send(8'h02);
        send(8'h07);
        idle(TIMEOUT - 1);
        check("to_err_early", err, 0);
        k = 0;
        while (!err && k < 6) begin
            tick();
            k++;
        end
        check("to_err", err, 1);
        check("to_done", done, 0);
        check("to_cpu_reset", cpu_reset, 1);
        check_writes("to_writes", 1);
        // Back in IDLE: non-sync bytes must be dropped.
        clear_log();
        send(8'h03);
        send(8'h11);
        idle(2);
        check("to_idle_no_write", wr_addr.size(), 0);
        check("to_idle_err_sticky", err, 1);
        load_test2_payload();
        send_frame(8'h03, 8'h9A, 0);
        check("to_recover_done", done, 1);
        check("to_recover_err", err, 0);
        check_writes("to_recover_writes", 3);

        // Async reset mid-DATA.
        clear_log();
        send(8'hA5);
        send(8'h05);
        send(8'h44);
        check("ar_we_before", imem_we, 1);
        #2 reset = 1'b1;
        #1;
        check("ar_we", imem_we, 0);
        check("ar_cpu_reset", cpu_reset, 1);
        check("ar_done", done, 0);
        check("ar_err", err, 0);
        check("ar_byte_cnt", byte_cnt, 0);
        check("ar_in_ready", in_ready, 0);
        tick();
        reset = 1'b0;
        tick();
        clear_log();
        load_test2_payload();
        send_frame(8'h03, 8'h9A, 1);
        check("ar_recover_done", done, 1);
        check("ar_recover_cnt", byte_cnt, 3);
        check_writes("ar_recover_writes", 3);

        // Table-driven frames.
        foreach (vecs[v]) begin
            len = (vecs[v].len == 8'h00) ? 256 : int'(vecs[v].len);
            for (int i = 0; i < len; i++) pay[i] = vecs[v].base + 8'(i) * vecs[v].step;
            clear_log();
            send_frame(vecs[v].len, vecs[v].chk, (len > 8) ? 0 : 2);
            check($sformatf("vec%0d_done", v), done, vecs[v].exp_done);
            check($sformatf("vec%0d_err", v), err, vecs[v].exp_err);
            check($sformatf("vec%0d_cpu_reset", v), cpu_reset, vecs[v].exp_cpu_reset);
            check($sformatf("vec%0d_byte_cnt", v), byte_cnt, vecs[v].exp_cnt);
            check_writes($sformatf("vec%0d_writes", v), len);
        end

        // Randomised frames against a frame-level model.
        for (int f = 0; f < 40; f++) begin
            len = $urandom_range(12, 1);
            sum = 8'h00;
            for (int i = 0; i < len; i++) begin
                pay[i] = 8'($urandom_range(255, 0));
                sum    = sum + pay[i];
            end
            good = ($urandom_range(3, 0) != 0);
            chk  = 8'h00 - sum;
            if (!good) chk = chk + 8'($urandom_range(255, 1));
            for (int j = $urandom_range(3, 0); j > 0; j--) begin
                b = 8'($urandom_range(254, 0));
                if (b >= 8'hA5) b = b + 8'h01;
                send(b);
                idle($urandom_range(2, 0));
            end
            clear_log();
            send_frame(8'(len), chk, 3);
            check($sformatf("rnd%0d_done", f), done, good);
            check($sformatf("rnd%0d_err", f), err, !good);
            check($sformatf("rnd%0d_cpu_reset", f), cpu_reset, !good);
            check($sformatf("rnd%0d_byte_cnt", f), byte_cnt, len);
            check_writes($sformatf("rnd%0d_writes", f), len);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
